// File: rtl/fft_sched_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 SDF FFT scheduler.
// Holds the scheduler state enum plus stage offset, total latency and bit-reverse functions.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Cycle offset of stage s: the delay lines of all earlier stages plus their register slices.
    function automatic int stage_off(input int s, input int n_log2, input int pipe);
        int off;
        off = 0;
        for (int k = 0; k < s; k++) begin
            off += (1 << n_log2) >> (k + 1);
        end
        return off + pipe * s;
    endfunction

    function automatic int total_lat(input int n_log2, input int pipe);
        return ((1 << n_log2) - 1) + pipe * n_log2;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[w-1-i] = x[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_vld_shreg.sv
// Enabled valid-tracking delay line for the SDF scheduler.
// Shifts only on enable so sample validity stays aligned with the stalled datapath.
module fft_vld_shreg #(
    parameter int DEPTH = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic din,
    output logic vsr_tap,
    output logic vsr_empty
);

    logic [DEPTH-1:0] vsr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsr <= '0;
        end else if (en) begin
            vsr <= {vsr[DEPTH-2:0], din};
        end
    end

    assign vsr_tap   = vsr[DEPTH-1];
    assign vsr_empty = ~|vsr;

endmodule

// File: rtl/fft_sdf_sched.sv
// Central scheduler for the radix-2 SDF FFT: sample counter, pipeline enable, stage selects, output strobes.
// Define BITREV_ADDR_EN to emit dout_idx as the natural frequency bin instead of arrival order.
module fft_sdf_sched
    import fft_sched_pkg::*;
#(
    parameter int N_LOG2 = 9,
    parameter int PIPE   = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              pipe_en,
    output logic [N_LOG2-1:0] stage_sel,
    output logic              dout_valid,
    output logic              dout_last,
    output logic [N_LOG2-1:0] dout_idx,
    output logic              busy,
    output logic              frame_err
);

    localparam int N         = 1 << N_LOG2;
    localparam int TOTAL_LAT = total_lat(N_LOG2, PIPE);
    localparam logic [N_LOG2-1:0] CNT_MAX = N_LOG2'(N - 1);

    state_t            state;
    state_t            state_nxt;
    logic [N_LOG2-1:0] in_cnt;
    logic [N_LOG2-1:0] out_cnt;
    logic              last_acc;
    logic              len_bad;
    logic              go_idle;
    logic              vsr_tap;
    logic              vsr_empty;

    // A frame boundary must coincide exactly with the counter wrap; anything else is a length error.
    assign len_bad = din_valid & (din_last ^ (in_cnt == CNT_MAX));
    assign go_idle = (state == FLUSH) && (state_nxt == IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (din_valid) state_nxt = RUN;
            RUN:     if (last_acc && !din_valid) state_nxt = FLUSH;
            FLUSH: begin
                if (din_valid) begin
                    state_nxt = RUN;
                end else if (vsr_empty) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pipe_en    = din_valid | (state == FLUSH);
        busy       = (state != IDLE);
        dout_valid = pipe_en & vsr_tap;
        dout_last  = dout_valid & (out_cnt == CNT_MAX);
`ifdef BITREV_ADDR_EN
        dout_idx   = N_LOG2'(bitrev(32'(out_cnt), N_LOG2));
`else
        dout_idx   = out_cnt;
`endif
    end

    // Counters restart from zero on return to IDLE so the next frame begins phase-aligned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            last_acc  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= len_bad;
            last_acc  <= din_valid & din_last;
            if (go_idle) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (pipe_en) begin
                    in_cnt <= len_bad ? '0 : in_cnt + 1'b1;
                end
                if (dout_valid) begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end

    // Each stage sees the shared counter delayed by its own offset; its MSB-side bit picks butterfly vs fill.
    for (genvar s = 0; s < N_LOG2; s++) begin : g_sel
        localparam logic [N_LOG2-1:0] OFF_S = N_LOG2'(stage_off(s, N_LOG2, PIPE) % N);
        logic [N_LOG2-1:0] phase;
        assign phase        = in_cnt - OFF_S;
        assign stage_sel[s] = pipe_en & phase[N_LOG2-1-s];
    end

    fft_vld_shreg #(
        .DEPTH(TOTAL_LAT)
    ) u_vsr (
        .clk      (clk),
        .rstn     (rstn),
        .en       (pipe_en),
        .din      (din_valid),
        .vsr_tap  (vsr_tap),
        .vsr_empty(vsr_empty)
    );

endmodule

// File: tb/tb_fft_sdf_sched.sv
// Scoreboard bench for fft_sdf_sched at N_LOG2=3, PIPE=1.
// Stimulus pushes expected output strobes; a negedge monitor pops and compares on dout_valid.
module tb_fft_sdf_sched;

    localparam int N_LOG2    = 3;
    localparam int PIPE      = 1;
    localparam int N         = 8;
    localparam int TOTAL_LAT = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_last = 1'b0;
    logic       pipe_en;
    logic [2:0] stage_sel;
    logic       dout_valid;
    logic       dout_last;
    logic [2:0] dout_idx;
    logic       busy;
    logic       frame_err;

    fft_sdf_sched #(
        .N_LOG2(N_LOG2),
        .PIPE  (PIPE)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_last  (din_last),
        .pipe_en   (pipe_en),
        .stage_sel (stage_sel),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .dout_idx  (dout_idx),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out = 0;
    int   n_last = 0;
    int   n_ferr = 0;
    int   en_cyc = 0;
    int   first_in_en = -1;
    int   first_out_en = -1;

    // stage_sel {s2,s1,s0} for in_cnt 0..7: s0=bit2(c), s1=bit1(c-5), s2=bit0(c-8)
    logic [2:0] SEL_TAB [8] = '{3'b010, 3'b100, 3'b000, 3'b110, 3'b011, 3'b101, 3'b001, 3'b111};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_idx(input int k);
        logic [2:0] v;
        v = 3'(k);
`ifdef BITREV_ADDR_EN
        return {v[0], v[1], v[2]};
`else
        return v;
`endif
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (din_valid && first_in_en < 0) first_in_en = en_cyc;
            if (dout_valid) begin
                exp_t e;
                check("dout_valid_needs_pipe_en", pipe_en, 1);
                n_out++;
                if (dout_last) n_last++;
                if (first_out_en < 0) first_out_en = en_cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dout: got idx %0d with nothing expected at %0t", dout_idx, $time);
                end else begin
                    e = sb.pop_front();
                    check("dout_idx", dout_idx, e.idx);
                    check("dout_last", dout_last, e.last);
                end
            end
            if (frame_err) n_ferr++;
            if (pipe_en) en_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic last, input bit push, input logic [2:0] idx, input logic elast,
                        input bit chk_sel, input logic [2:0] sel);
        exp_t e;
        din_valid = 1'b1;
        din_last  = last;
        if (push) begin
            e.idx  = idx;
            e.last = elast;
            sb.push_back(e);
        end
        @(negedge clk);
        if (chk_sel) check("stage_sel", stage_sel, sel);
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        check("stall_pipe_en", pipe_en, 0);
        tick();
    endtask

    task automatic send_frame(input int len, input bit push, input bit chk_sel);
        for (int k = 0; k < len; k++) begin
            send(k == len - 1, push, exp_idx(k), k == N - 1, chk_sel, SEL_TAB[k % 8]);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pipe_en"}, pipe_en, 0);
        check({name, "_stage_sel"}, stage_sel, 0);
        check({name, "_dout_valid"}, dout_valid, 0);
        check({name, "_dout_last"}, dout_last, 0);
        check({name, "_dout_idx"}, dout_idx, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_out;
        int base_last;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rstn = 1'b1;
        tick();

        // Single frame, back-to-back samples: latency, stage selects, last strobe, drain.
        send_frame(8, 1'b1, 1'b1);
        check("busy_after_frame", busy, 1);
        wait_idle("frame1");
        check("frame1_sb_empty", sb.size(), 0);
        check("frame1_out_count", n_out, 8);
        check("frame1_last_count", n_last, 1);
        check("latency_enabled_cycles", first_out_en - first_in_en, TOTAL_LAT);
        check("frame1_no_frame_err", n_ferr, 0);

        // Four back-to-back frames with mid-frame stalls.
        base_out  = n_out;
        base_last = n_last;
        for (int j = 0; j < 32; j++) begin
            if ((j % 8) != 0 && $urandom_range(0, 9) < 3) gap();
            send(j % 8 == 7, 1'b1, exp_idx(j % 8), j % 8 == 7, 1'b0, 3'b000);
        end
        wait_idle("gaps");
        check("gaps_out_count", n_out - base_out, 32);
        check("gaps_last_count", n_last - base_last, 4);
        check("gaps_sb_empty", sb.size(), 0);
        check("gaps_no_frame_err", n_ferr, 0);

        // Short frame: din_last at in_cnt=5.
        send_frame(6, 1'b1, 1'b0);
        @(negedge clk);
        check("frame_err_pulse", frame_err, 1);
        tick();
        @(negedge clk);
        check("frame_err_single", frame_err, 0);
        tick();
        wait_idle("short");
        check("short_sb_empty", sb.size(), 0);
        check("short_ferr_count", n_ferr, 1);
        base_last = n_last;
        send_frame(8, 1'b1, 1'b0);
        wait_idle("resync");
        check("resync_sb_empty", sb.size(), 0);
        check("resync_last_count", n_last - base_last, 1);
        check("resync_ferr_count", n_ferr, 1);

        // Reset during flush, before any output of the frame emerges.
        base_out = n_out;
        send_frame(8, 1'b0, 1'b0);
        tick();
        tick();
        check("flush_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        @(negedge clk);
        check_all_zero("held_reset");
        tick();
        rstn = 1'b1;
        repeat (30) tick();
        check("post_reset_no_output", n_out - base_out, 0);
        check("post_reset_busy", busy, 0);

        // Recovery frame after reset.
        send_frame(8, 1'b1, 1'b1);
        wait_idle("recover");
        check("recover_out_count", n_out - base_out, 8);
        check("recover_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
